accum_core_ctrl: RTL

Control sequencer for the 8-bit accumulator processor. It fetches 9-bit instructions, decodes them into operation/operand signals for the external ALU, and commits ALU results to the accumulator, overflow flag and a 16×8 register file. It also runs the data-memory request/acknowledge handshake for load/store and handles halt and branch. It sits between instruction ROM, data memory and the ALU, driving the ALU's inputs and consuming its outputs.

---
 rtl/accum_pkg.sv | 42 ++++
 rtl/accum_reg_file.sv | 27 ++
 rtl/accum_core_ctrl.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/accum_pkg.sv
// Shared types and constants for the 8-bit accumulator processor control path.
package accum_pkg;

  localparam int INST_W = 9;
  localparam int DATA_W = 8;
  localparam int REG_AW = 4;
  localparam int REG_N  = 16;

  typedef enum logic [3:0] {
    OP_TAKE   = 4'h0,
    OP_PUT    = 4'h1,
    OP_LOAD   = 4'h2,
    OP_STORE  = 4'h3,
    OP_XOR    = 4'h4,
    OP_NAND   = 4'h5,
    OP_SHL    = 4'h6,
    OP_SHR    = 4'h7,
    OP_LOOKUP = 4'h8,
    OP_LSN    = 4'h9,
    OP_EQL    = 4'hA,
    OP_ADD    = 4'hB,
    OP_SUB    = 4'hC,
    OP_OF0    = 4'hD,
    OP_HALT   = 4'hE,
    OP_TBA    = 4'hF
  } op_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_MEM,
    S_HALT
  } state_t;

  // Entry 0 is the rightmost byte.
  localparam logic [REG_N-1:0][DATA_W-1:0] LOOKUP_TABLE = {
    8'h2F, 8'h9A, 8'h4D, 8'hAB, 8'hD8, 8'h6C, 8'h36, 8'h1B,
    8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01
  };

endpackage

// File: rtl/accum_reg_file.sv
// 16x8 register file: one combinational read port, one synchronous write port.
module accum_reg_file
  import accum_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [REG_AW-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] regs_q [REG_N];

  // NOTE: every entry is reset, so this array lands in flops rather than a RAM macro.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_N; i++) regs_q[i] <= '0;
    end else if (we) begin
      regs_q[waddr] <= wdata;
    end
  end

  assign rdata = regs_q[raddr];

endmodule

// File: rtl/accum_core_ctrl.sv
// Fetch/decode/commit sequencer for the accumulator processor, with the
// external ALU driven combinationally during EXEC and a req/ack data-memory port.
module accum_core_ctrl
  import accum_pkg::*;
#(
  parameter int PC_W = 8
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              start,
  output logic [PC_W-1:0]   inst_addr,
  input  logic [INST_W-1:0] inst_data,
  output logic              alu_type,
  output logic [3:0]        alu_op,
  output logic [DATA_W-1:0] alu_acc,
  output logic [DATA_W-1:0] alu_reg,
  output logic              alu_ovf,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_ovf_result,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [DATA_W-1:0] acc,
  output logic              ovf,
  output logic              done
);

  state_t              state_q, state_d;
  logic [PC_W-1:0]     pc_q, pc_d, pc_inc;
  logic [DATA_W-1:0]   acc_q, acc_d;
  logic                ovf_q, ovf_d;
  logic [INST_W-1:0]   ir_q, ir_d;
  logic [INST_W-1:0]   inst;
  op_t                 op;
  logic [REG_AW-1:0]   r;
  logic [DATA_W-1:0]   rf_rdata;
  logic                rf_we;

  // ROM data is only valid in EXEC; afterwards the latched copy carries the instruction.
  assign inst   = (state_q == S_EXEC) ? inst_data : ir_q;
  assign op     = op_t'(inst[7:4]);
  assign r      = inst[3:0];
  assign ir_d   = inst;
  assign pc_inc = pc_q + PC_W'(1);

  accum_reg_file u_reg_file (
    .clk   (CLK),
    .rst   (RESET),
    .we    (rf_we),
    .waddr (r),
    .wdata (acc_q),
    .raddr (r),
    .rdata (rf_rdata)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      ir_q    <= ir_d;
    end
  end

  // NOTE: each always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_HALT: if (start) state_d = S_FETCH;
      S_FETCH:        state_d = S_EXEC;
      S_EXEC: begin
        if (inst[8])                              state_d = S_FETCH;
        else if (op == OP_LOAD || op == OP_STORE) state_d = S_MEM;
        else if (op == OP_HALT)                   state_d = S_HALT;
        else                                      state_d = S_FETCH;
      end
      S_MEM:          if (mem_ack) state_d = S_FETCH;
      default:        state_d = S_IDLE;
    endcase
  end

  always_comb begin
    pc_d  = pc_q;
    acc_d = acc_q;
    ovf_d = ovf_q;
    rf_we = 1'b0;
    unique case (state_q)
      S_IDLE, S_HALT: if (start) pc_d = '0;
      S_EXEC: begin
        pc_d = pc_inc;
        if (inst[8]) begin
          acc_d = inst[7:0];
        end else begin
          unique case (op)
            OP_TAKE, OP_XOR, OP_NAND, OP_SHL, OP_SHR, OP_LSN, OP_EQL, OP_SUB:
                       acc_d = alu_result;
            OP_ADD: begin
              acc_d = alu_result;
              ovf_d = alu_ovf_result;
            end
            OP_PUT:    rf_we = 1'b1;
            OP_LOOKUP: acc_d = LOOKUP_TABLE[r];
            OP_OF0:    ovf_d = 1'b0;
            OP_LOAD, OP_STORE, OP_HALT:
                       pc_d = pc_q;
            OP_TBA:    if (acc_q != '0) pc_d = PC_W'(rf_rdata);
          endcase
        end
      end
      S_MEM: begin
        if (mem_ack) begin
          pc_d = pc_inc;
          if (op == OP_LOAD) acc_d = mem_rdata;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    inst_addr = pc_q;
    alu_type  = inst[8];
    alu_op    = inst[7:4];
    alu_acc   = acc_q;
    alu_reg   = rf_rdata;
    alu_ovf   = ovf_q;
    mem_req   = (state_q == S_MEM);
    mem_we    = (op == OP_STORE);
    mem_addr  = rf_rdata;
    mem_wdata = acc_q;
    acc       = acc_q;
    ovf       = ovf_q;
    done      = (state_q == S_HALT);
  end

endmodule
